demux_1b_sipo: RTL and testbench

Bit-serial to parallel capture unit: a 1-bit input stream is demultiplexed, one bit per accepted cycle, into successive positions of a WIDTH-bit word register. When the word is complete it is presented on a valid/ready output port. It is the receive-side counterpart of the 2:1 mux selection path used for bit-serial datapaths in the lab-6 design. It turns a serially selected bit stream back into an operand word for the parallel datapath.

---
 rtl/demux_1b_sipo.sv | 88 ++++++++
 tb/tb_demux_1b_sipo.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1b_sipo.sv
// Bit-serial to parallel capture: each accepted bit is written (demuxed, not
// shifted) into the next position of a WIDTH-bit word. The completed word is
// offered on a valid/ready port. in_ready is low while the word is held.
module demux_1b_sipo #(
  parameter int unsigned WIDTH     = 16,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_bit,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_word,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] bit_count
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastIdx = CW'(WIDTH - 1);

  typedef enum logic [0:0] {StCollect, StFull} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  word_q, word_d;
  logic [CW-1:0]     wr_idx;

  // Bit position written by the current accept.
  always_comb begin
    wr_idx = LSB_FIRST ? count_q : (LastIdx - count_q);
  end

  // Next-state: flush aborts everything; otherwise collect bits or wait for transfer.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    word_d  = word_q;
    if (flush) begin
      // The word register is deliberately left as-is; only the handshake state is dropped.
      state_d = StCollect;
      count_d = '0;
    end else begin
      unique case (state_q)
        StCollect: begin
          if (in_valid) begin
            word_d[wr_idx] = in_bit;
            if (count_q == LastIdx) begin
              count_d = '0;
              state_d = StFull;
            end else begin
              count_d = count_q + CW'(1);
            end
          end
        end
        StFull: begin
          if (out_ready) begin
            state_d = StCollect;
          end
        end
        default: state_d = StCollect;
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StCollect;
      count_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      word_q  <= word_d;
    end
  end

  // Outputs come straight from registers; no input-to-output path.
  always_comb begin
    out_valid = (state_q == StFull);
    in_ready  = (state_q == StCollect);
    out_word  = word_q;
    bit_count = count_q;
  end

endmodule

// File: tb/tb_demux_1b_sipo.sv
// Directed self-checking bench for demux_1b_sipo, WIDTH=8. A second instance
// with LSB_FIRST=0 shares all inputs to check MSB-first placement.
module tb_demux_1b_sipo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid;
  logic [7:0] out_word;
  logic [2:0] bit_count;
  logic       in_ready_m, out_valid_m;
  logic [7:0] out_word_m;
  logic [2:0] bit_count_m;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux_1b_sipo #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_word (out_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bit_count(bit_count)
  );

  demux_1b_sipo #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .in_ready (in_ready_m),
    .out_word (out_word_m),
    .out_valid(out_valid_m),
    .out_ready(out_ready),
    .bit_count(bit_count_m)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (bit_count !== 3'd0) begin
      errors++; $display("FAIL reset_bit_count: got %0d expected 0", bit_count);
    end
    checks++;
    if (out_word !== 8'h00) begin
      errors++; $display("FAIL reset_out_word: got %h expected 00", out_word);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat;
    pat = 8'h4D;  // stream 1,0,1,1,0,0,1,0 is pat[0]..pat[7]
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_bit = pat[i];
      step();
      if (i < 7) begin
        checks++;
        if (out_valid !== 1'b0 || bit_count !== 3'(i + 1)) begin
          errors++;
          $display("FAIL b2b_collect[%0d]: got valid=%b count=%0d expected valid=0 count=%0d",
                   i, out_valid, bit_count, i + 1);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_full: got valid=%b ready=%b expected 1/0", out_valid, in_ready);
    end
    checks++;
    if (out_word !== 8'h4D) begin
      errors++; $display("FAIL b2b_word_lsb: got %h expected 4d", out_word);
    end
    checks++;
    if (out_valid_m !== 1'b1 || out_word_m !== 8'hB2) begin
      errors++;
      $display("FAIL b2b_word_msb: got valid=%b word=%h expected 1/b2", out_valid_m, out_word_m);
    end
    checks++;
    if (bit_count !== 3'd0) begin
      errors++; $display("FAIL b2b_count_wrap: got %0d expected 0", bit_count);
    end
    // Bit offered while in_ready=0 must be ignored.
    in_bit = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || bit_count !== 3'd0) begin
      errors++;
      $display("FAIL b2b_after: got valid=%b ready=%b count=%0d expected 0/1/0",
               out_valid, in_ready, bit_count);
    end
  endtask

  task automatic test_gaps_backpressure();
    logic [7:0] pat;
    pat = 8'h4D;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_bit   = pat[i];
      step();
      if (i < 7) begin
        checks++;
        if (bit_count !== 3'(i + 1)) begin
          errors++; $display("FAIL gap_accept[%0d]: got %0d expected %0d", i, bit_count, i + 1);
        end
        in_valid = 1'b0;
        in_bit   = ~pat[i];
        step();
        checks++;
        if (bit_count !== 3'(i + 1)) begin
          errors++; $display("FAIL gap_idle[%0d]: got %0d expected %0d", i, bit_count, i + 1);
        end
      end
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_bit   = c[0];
      step();
      checks++;
      if (out_valid !== 1'b1 || out_word !== 8'h4D || bit_count !== 3'd0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: got valid=%b word=%h count=%0d ready=%b expected 1/4d/0/0",
                 c, out_valid, out_word, bit_count, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || bit_count !== 3'd0) begin
      errors++;
      $display("FAIL hold_release: got valid=%b ready=%b count=%0d expected 0/1/0",
               out_valid, in_ready, bit_count);
    end
  endtask

  task automatic test_flush_mid_word();
    logic [7:0] pat;
    pat = 8'hA5;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (bit_count !== 3'd3) begin
      errors++; $display("FAIL flush_pre_count: got %0d expected 3", bit_count);
    end
    flush  = 1'b1;
    in_bit = 1'b0;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (bit_count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_count: got count=%0d valid=%b expected 0/0", bit_count, out_valid);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_bit = pat[i];
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_word !== 8'hA5) begin
      errors++;
      $display("FAIL flush_next_word: got valid=%b word=%h expected 1/a5", out_valid, out_word);
    end
    step();
  endtask

  task automatic test_flush_rst_full();
    logic [7:0] pat;
    pat = 8'h3C;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_bit = pat[i];
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_word !== 8'h3C) begin
      errors++;
      $display("FAIL full_pre_flush: got valid=%b word=%h expected 1/3c", out_valid, out_word);
    end
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || bit_count !== 3'd0) begin
      errors++;
      $display("FAIL full_flush: got valid=%b ready=%b count=%0d expected 0/1/0",
               out_valid, in_ready, bit_count);
    end
    in_valid = 1'b1;
    in_bit   = 1'b1;
    for (int i = 0; i < 5; i++) step();
    in_valid = 1'b0;
    checks++;
    if (bit_count !== 3'd5) begin
      errors++; $display("FAIL rst_pre_count: got %0d expected 5", bit_count);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || bit_count !== 3'd0 || out_word !== 8'h00 ||
        out_word_m !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_word: got valid=%b ready=%b count=%0d word=%h msb=%h expected 0/1/0/00/00",
               out_valid, in_ready, bit_count, out_word, out_word_m);
    end
  endtask

  task automatic test_throughput();
    logic [7:0] words [4];
    logic [7:0] cur;
    int w, b, pulses;
    logic acc;
    words[0] = 8'h12; words[1] = 8'hF0; words[2] = 8'h5A; words[3] = 8'hC3;
    w = 0; b = 0; pulses = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 36; c++) begin
      if (w < 4) begin
        cur      = words[w];
        in_valid = 1'b1;
        in_bit   = cur[b[2:0]];
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid & in_ready;
      step();
      if (acc) begin
        b++;
        if (b == 8) begin
          b = 0;
          w++;
        end
      end
      checks++;
      if (out_valid !== ((c % 9) == 7)) begin
        errors++;
        $display("FAIL tput_valid[%0d]: got %b expected %b", c, out_valid, (c % 9) == 7);
      end
      if ((c % 9) == 7) begin
        cur = words[c / 9];
        checks++;
        if (out_word !== cur) begin
          errors++; $display("FAIL tput_word[%0d]: got %h expected %h", c / 9, out_word, cur);
        end
      end
      if (out_valid === 1'b1) pulses++;
    end
    in_valid = 1'b0;
    checks++;
    if (pulses != 4) begin
      errors++; $display("FAIL tput_pulses: got %0d expected 4", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps_backpressure();
    test_flush_mid_word();
    test_flush_rst_full();
    test_throughput();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
